mem_loader: RTL and testbench

- Runtime writer for the processor's instruction memory (1024 x 16) and data memory (256 x 8). Replaces file-based preloading.
- Accepts a framed byte stream through a valid/ready handshake and decodes it into single-cycle write strobes on the memory write ports.
- Holds the CPU (cpu_hold) until a RUN command arrives.
- Sits between the host byte link (UART receiver or testbench) and the memory block.

---
 rtl/mem_loader.sv | 173 +++++++++++++++++
 tb/tb_mem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Runtime loader for instruction (1024x16) and data (256x8) memories.
// Decodes a framed byte stream into registered single-cycle write strobes.
module mem_loader #(
    parameter logic [7:0] HDR_INSTR = 8'hA5,
    parameter logic [7:0] HDR_DATA  = 8'h5A,
    parameter logic [7:0] HDR_RUN   = 8'h3C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        instr_wr_en,
    output logic [9:0]  instr_wr_addr,
    output logic [15:0] instr_wr_data,
    output logic        store_to_mem,
    output logic [7:0]  data_wr_addr,
    output logic [7:0]  datamem_wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        I_AHI,
        I_ALO,
        COUNT,
        I_PHI,
        I_PLO,
        D_ADDR,
        D_PAY
    } state_t;

    state_t      state, state_nx;
    logic        is_instr, is_instr_nx;
    logic [9:0]  addr, addr_nx;
    logic [8:0]  items, items_nx;
    logic [7:0]  hi, hi_nx;
    logic        fire;

    logic        instr_wr_en_nx;
    logic [9:0]  instr_wr_addr_nx;
    logic [15:0] instr_wr_data_nx;
    logic        store_to_mem_nx;
    logic [7:0]  data_wr_addr_nx;
    logic [7:0]  datamem_wr_data_nx;
    logic        cpu_hold_nx;
    logic        load_done_nx;
    logic        frame_err_nx;

    // The loader never back-pressures; every valid byte is consumed.
    assign byte_ready = 1'b1;
    assign fire       = byte_valid && byte_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            is_instr        <= 1'b0;
            addr            <= '0;
            items           <= '0;
            hi              <= '0;
            instr_wr_en     <= 1'b0;
            instr_wr_addr   <= '0;
            instr_wr_data   <= '0;
            store_to_mem    <= 1'b0;
            data_wr_addr    <= '0;
            datamem_wr_data <= '0;
            cpu_hold        <= 1'b1;
            load_done       <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            state           <= state_nx;
            is_instr        <= is_instr_nx;
            addr            <= addr_nx;
            items           <= items_nx;
            hi              <= hi_nx;
            instr_wr_en     <= instr_wr_en_nx;
            instr_wr_addr   <= instr_wr_addr_nx;
            instr_wr_data   <= instr_wr_data_nx;
            store_to_mem    <= store_to_mem_nx;
            data_wr_addr    <= data_wr_addr_nx;
            datamem_wr_data <= datamem_wr_data_nx;
            cpu_hold        <= cpu_hold_nx;
            load_done       <= load_done_nx;
            frame_err       <= frame_err_nx;
        end
    end

    always_comb begin
        state_nx           = state;
        is_instr_nx        = is_instr;
        addr_nx            = addr;
        items_nx           = items;
        hi_nx              = hi;
        instr_wr_en_nx     = 1'b0;
        instr_wr_addr_nx   = instr_wr_addr;
        instr_wr_data_nx   = instr_wr_data;
        store_to_mem_nx    = 1'b0;
        data_wr_addr_nx    = data_wr_addr;
        datamem_wr_data_nx = datamem_wr_data;
        cpu_hold_nx        = cpu_hold;
        load_done_nx       = 1'b0;
        frame_err_nx       = frame_err;

        if (fire) begin
            unique case (state)
                IDLE: begin
                    if (byte_in == HDR_INSTR) begin
                        state_nx    = I_AHI;
                        is_instr_nx = 1'b1;
                        cpu_hold_nx = 1'b1;
                    end else if (byte_in == HDR_DATA) begin
                        state_nx    = D_ADDR;
                        is_instr_nx = 1'b0;
                        cpu_hold_nx = 1'b1;
                    end else if (byte_in == HDR_RUN) begin
                        cpu_hold_nx = 1'b0;
                    end else begin
                        frame_err_nx = 1'b1;
                    end
                end
                I_AHI: begin
                    addr_nx  = {byte_in[1:0], 8'h00};
                    state_nx = I_ALO;
                end
                I_ALO: begin
                    addr_nx[7:0] = byte_in;
                    state_nx     = COUNT;
                end
                D_ADDR: begin
                    addr_nx  = {2'b00, byte_in};
                    state_nx = COUNT;
                end
                COUNT: begin
                    // A zero count encodes a full 256-item burst.
                    items_nx = (byte_in == 8'h00) ? 9'd256 : {1'b0, byte_in};
                    state_nx = is_instr ? I_PHI : D_PAY;
                end
                I_PHI: begin
                    hi_nx    = byte_in;
                    state_nx = I_PLO;
                end
                I_PLO: begin
                    instr_wr_en_nx   = 1'b1;
                    instr_wr_addr_nx = addr;
                    instr_wr_data_nx = {hi, byte_in};
                    addr_nx          = addr + 10'd1;
                    items_nx         = items - 9'd1;
                    if (items == 9'd1) begin
                        load_done_nx = 1'b1;
                        state_nx     = IDLE;
                    end else begin
                        state_nx = I_PHI;
                    end
                end
                D_PAY: begin
                    store_to_mem_nx    = 1'b1;
                    data_wr_addr_nx    = addr[7:0];
                    datamem_wr_data_nx = byte_in;
                    addr_nx            = {2'b00, addr[7:0] + 8'd1};
                    items_nx           = items - 9'd1;
                    if (items == 9'd1) begin
                        load_done_nx = 1'b1;
                        state_nx     = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes are queued as bytes
// are driven and retired when the DUT raises a write strobe.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        instr_wr_en;
    logic [9:0]  instr_wr_addr;
    logic [15:0] instr_wr_data;
    logic        store_to_mem;
    logic [7:0]  data_wr_addr;
    logic [7:0]  datamem_wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        frame_err;

    typedef struct {
        bit          instr;
        logic [9:0]  addr;
        logic [15:0] data;
        bit          last;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] wbuf[256];
    logic [7:0]  bbuf[256];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          done_cnt = 0;

    mem_loader dut (
        .clk(clk),
        .reset(reset),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .instr_wr_en(instr_wr_en),
        .instr_wr_addr(instr_wr_addr),
        .instr_wr_data(instr_wr_data),
        .store_to_mem(store_to_mem),
        .data_wr_addr(data_wr_addr),
        .datamem_wr_data(datamem_wr_data),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            int g = int'($urandom_range(0, 2));
            repeat (g) begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic instr_frame(input logic [9:0] a, input int n, input bit gaps);
        exp_t e;
        send_byte(8'hA5, gaps);
        send_byte({6'b000000, a[9:8]}, gaps);
        send_byte(a[7:0], gaps);
        send_byte(8'(n), gaps);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i][15:8], gaps);
            e.instr = 1'b1;
            e.addr  = a + 10'(i);
            e.data  = wbuf[i];
            e.last  = (i == n - 1);
            sb.push_back(e);
            send_byte(wbuf[i][7:0], gaps);
        end
    endtask

    task automatic data_frame(input logic [7:0] a, input int n, input bit gaps);
        exp_t e;
        send_byte(8'h5A, gaps);
        send_byte(a, gaps);
        send_byte(8'(n), gaps);
        for (int i = 0; i < n; i++) begin
            e.instr = 1'b0;
            e.addr  = {2'b00, a + 8'(i)};
            e.data  = {8'h00, bbuf[i]};
            e.last  = (i == n - 1);
            sb.push_back(e);
            send_byte(bbuf[i], gaps);
        end
    endtask

    // Retire one scoreboard entry per observed write strobe.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (instr_wr_en || store_to_mem) begin
            chk("excl", 32'(instr_wr_en & store_to_mem), 32'd0);
            if (sb.size() == 0) begin
                chk("unexp_wr", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_kind", 32'(instr_wr_en), 32'(e.instr));
                if (e.instr) begin
                    chk("i_addr", 32'(instr_wr_addr), 32'(e.addr));
                    chk("i_data", 32'(instr_wr_data), 32'(e.data));
                end else begin
                    chk("d_addr", 32'(data_wr_addr), 32'(e.addr));
                    chk("d_data", 32'(datamem_wr_data), 32'(e.data));
                end
                chk("done", 32'(load_done), 32'(e.last));
            end
        end else if (load_done === 1'b1) begin
            chk("stray_done", 32'd1, 32'd0);
        end
        if (load_done === 1'b1) done_cnt++;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd1);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_iwe"}, 32'(instr_wr_en), 32'd0);
        chk({tag, "_st"}, 32'(store_to_mem), 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_iaddr"}, 32'(instr_wr_addr), 32'd0);
        chk({tag, "_idata"}, 32'(instr_wr_data), 32'd0);
        chk({tag, "_daddr"}, 32'(data_wr_addr), 32'd0);
        chk({tag, "_ddata"}, 32'(datamem_wr_data), 32'd0);
    endtask

    initial begin
        int d0;
        exp_t e;
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        idle(3);
        chk_reset_vals("rst");
        reset = 1'b0;
        idle(1);

        // Two-word instruction load.
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'hABCD;
        d0 = done_cnt;
        instr_frame(10'h010, 2, 1'b0);
        chk("t1_hold", 32'(cpu_hold), 32'd1);
        idle(2);
        chk("t1_addr_hold", 32'(instr_wr_addr), 32'h011);
        chk("t1_data_hold", 32'(instr_wr_data), 32'hABCD);
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Data load wrapping past 0xFF.
        bbuf[0] = 8'h11;
        bbuf[1] = 8'h22;
        bbuf[2] = 8'h33;
        data_frame(8'hFE, 3, 1'b0);
        idle(2);
        chk("t2_drain", 32'(sb.size()), 32'd0);

        // Instruction wrap 0x3FF -> 0x000, then RUN.
        wbuf[0] = 16'h0001;
        wbuf[1] = 16'h0002;
        instr_frame(10'h3FF, 2, 1'b0);
        send_byte(8'h3C, 1'b0);
        chk("t3_run", 32'(cpu_hold), 32'd0);
        idle(1);
        chk("t3_run_hold", 32'(cpu_hold), 32'd0);
        send_byte(8'h5A, 1'b0);
        chk("t3_rehold", 32'(cpu_hold), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        e.instr = 1'b0;
        e.addr  = 10'h000;
        e.data  = 16'h003C;
        e.last  = 1'b1;
        sb.push_back(e);
        send_byte(8'h3C, 1'b0);
        chk("t3_hold_pay", 32'(cpu_hold), 32'd1);
        idle(2);
        chk("t3_drain", 32'(sb.size()), 32'd0);

        // Full 256-word burst with random valid gaps.
        for (int i = 0; i < 256; i++) wbuf[i] = 16'($urandom);
        d0 = done_cnt;
        instr_frame(10'h000, 256, 1'b1);
        idle(2);
        chk("t4_drain", 32'(sb.size()), 32'd0);
        chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Unknown header sets sticky error; loader keeps working.
        send_byte(8'h77, 1'b0);
        chk("t5_err", 32'(frame_err), 32'd1);
        bbuf[0] = 8'hC3;
        bbuf[1] = 8'h5A;
        data_frame(8'h40, 2, 1'b0);
        idle(2);
        chk("t5_err_sticky", 32'(frame_err), 32'd1);
        chk("t5_drain", 32'(sb.size()), 32'd0);

        // Reset mid-frame abandons the partial word.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        reset = 1'b1;
        idle(1);
        chk_reset_vals("mid");
        reset = 1'b0;
        idle(2);
        chk("t6_no_wr", 32'(instr_wr_en), 32'd0);
        wbuf[0] = 16'hBEEF;
        wbuf[1] = 16'h0F0F;
        wbuf[2] = 16'h5555;
        instr_frame(10'h155, 3, 1'b0);
        idle(3);
        chk("final_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
